// File: rtl/i2c_eeprom_write_if.sv
// Request/status interface of the I2C EEPROM byte-write master.
// The requester uses the master modport and the write engine uses the slave modport.
interface i2c_eeprom_write_if;
  logic       WRITE;
  logic [7:0] MEM_ADDR;
  logic [7:0] WR_DATA;
  logic       BUSY;
  logic       DONE;
  logic       ACK_ERR;
  logic [3:0] STATE_OUT;

  modport master (
    output WRITE, MEM_ADDR, WR_DATA,
    input  BUSY, DONE, ACK_ERR, STATE_OUT
  );

  modport slave (
    input  WRITE, MEM_ADDR, WR_DATA,
    output BUSY, DONE, ACK_ERR, STATE_OUT
  );
endinterface

// File: rtl/i2c_eeprom_write.sv
// I2C byte-write master: START, device address + W, word address, data, STOP,
// then a fixed hold-off for the EEPROM internal write cycle.
// SCL comes from a quarter-period divider; SDA is open-drain (drives 0 or Z).
module i2c_eeprom_write #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [6:0]  DEV_ADDR   = 7'b1010000,
  parameter int unsigned TWR_CYCLES = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  i2c_eeprom_write_if.slave bus,
  output logic              I2C_SCLK,
  inout  wire               I2C_SDAT
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TWR_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    ADDR  = 4'd2,
    ACK_A = 4'd3,
    WORD  = 4'd4,
    ACK_W = 4'd5,
    DATA  = 4'd6,
    ACK_D = 4'd7,
    STOP  = 4'd8,
    HOLD  = 4'd9
  } state_t;

  state_t            state, state_n;
  logic [1:0]        quarter, quarter_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [7:0]        shift, shift_n;
  logic [7:0]        addr_q, addr_n;
  logic [7:0]        data_q, data_n;
  logic              ack_err, ack_err_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              scl_q, sda_low_q;
  logic [1:0]        drive_n;
  logic [2:0]        wr_sync;
  logic              req;
  logic              tick;
  logic              sda_in;

  // SCL level and SDA pull-down for a given slot position ({scl, sda_low}).
  // SDA only moves while SCL is low, except the START/STOP edges.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q, logic msb);
    logic [1:0] d;
    d = 2'b10;
    case (st)
      START:            d = (q == 2'd0) ? 2'b10 : (q == 2'd3) ? 2'b01 : 2'b11;
      ADDR, WORD, DATA: d = {(q == 2'd1) || (q == 2'd2), ~msb};
      ACK_A, ACK_W, ACK_D: d = {(q == 2'd1) || (q == 2'd2), 1'b0};
      STOP:             d = (q == 2'd0) ? 2'b01 : (q == 2'd1) ? 2'b11 : 2'b10;
      default:          d = 2'b10;
    endcase
    return d;
  endfunction

  assign req      = wr_sync[2] & ~wr_sync[1];
  assign sda_in   = I2C_SDAT;
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_q;

  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.ACK_ERR   = ack_err;
  assign bus.STATE_OUT = state;

  // Two-flop synchroniser plus one delay flop for falling-edge detection of WRITE.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) wr_sync <= 3'b111;
    else        wr_sync <= {wr_sync[1:0], bus.WRITE};
  end

  // Next-state, datapath and pin decode; pins are decoded from next state so they leave a flop.
  always_comb begin
    state_n    = state;
    quarter_n  = quarter;
    bit_cnt_n  = bit_cnt;
    div_n      = div_cnt;
    hold_cnt_n = hold_cnt;
    shift_n    = shift;
    addr_n     = addr_q;
    data_n     = data_q;
    ack_err_n  = ack_err;
    busy_n     = busy;
    done_n     = 1'b0;
    tick       = 1'b0;

    case (state)
      IDLE: begin
        div_n = '0;
        if (req && !done) begin
          state_n   = START;
          quarter_n = 2'd0;
          bit_cnt_n = 3'd0;
          shift_n   = {DEV_ADDR, 1'b0};
          addr_n    = bus.MEM_ADDR;
          data_n    = bus.WR_DATA;
          ack_err_n = 1'b0;
          busy_n    = 1'b1;
        end
      end
      HOLD: begin
        div_n = '0;
        if (hold_cnt == HOLD_LAST) begin
          state_n    = IDLE;
          hold_cnt_n = '0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        tick  = (div_cnt == DIV_LAST);
        div_n = tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          quarter_n = quarter + 2'd1;
          case (state)
            START: if (quarter == 2'd3) state_n = ADDR;
            ADDR, WORD, DATA: begin
              if (quarter == 2'd3) begin
                shift_n   = {shift[6:0], 1'b0};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  case (state)
                    ADDR:    state_n = ACK_A;
                    WORD:    state_n = ACK_W;
                    default: state_n = ACK_D;
                  endcase
                end
              end
            end
            ACK_A, ACK_W, ACK_D: begin
              if (quarter == 2'd2 && sda_in) ack_err_n = 1'b1;
              if (quarter == 2'd3) begin
                if (ack_err) begin
                  state_n = STOP;
                end else begin
                  case (state)
                    ACK_A: begin
                      state_n = WORD;
                      shift_n = addr_q;
                    end
                    ACK_W: begin
                      state_n = DATA;
                      shift_n = data_q;
                    end
                    default: state_n = STOP;
                  endcase
                end
              end
            end
            STOP: begin
              if (quarter == 2'd3) begin
                hold_cnt_n = '0;
                if (ack_err) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                end else begin
                  state_n = HOLD;
                end
              end
            end
            default: state_n = IDLE;
          endcase
        end
      end
    endcase

    drive_n = bus_drive(state_n, quarter_n, shift_n[7]);
  end

  // State and datapath registers; reset aborts at once with the bus released.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd0;
      div_cnt   <= '0;
      hold_cnt  <= '0;
      shift     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      ack_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state     <= state_n;
      quarter   <= quarter_n;
      bit_cnt   <= bit_cnt_n;
      div_cnt   <= div_n;
      hold_cnt  <= hold_cnt_n;
      shift     <= shift_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      ack_err   <= ack_err_n;
      busy      <= busy_n;
      done      <= done_n;
      scl_q     <= drive_n[1];
      sda_low_q <= drive_n[0];
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_write.sv
// Scoreboard bench for i2c_eeprom_write: a bus decoder with an ACKing slave
// and a DONE monitor pop expectations queued by the stimulus process.
module tb_i2c_eeprom_write;

  localparam int CLK_DIV = 4;
  localparam int TWR     = 16;
  localparam int SLOT    = 4 * CLK_DIV;

  localparam logic [10:0] EV_START = 11'h400;
  localparam logic [10:0] EV_STOP  = 11'h500;

  typedef struct {
    logic ack_err;
    int   cycles;
  } done_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         nack_at;
    logic       exp_ack_err;
    int         exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl;
  wire  sda;
  logic slave_low = 1'b0;

  logic mon_en = 1'b0;
  int   nack_idx = 3;
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  int   done_target = 0;

  logic [10:0] exp_events[$];
  done_t       exp_done[$];

  logic       prev_scl, prev_sda, cur_scl, cur_sda, in_frame;
  int         bit_idx, byte_idx, busy_cnt;
  logic [7:0] shreg;

  i2c_eeprom_write_if bus();

  i2c_eeprom_write #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (7'b1010000),
    .TWR_CYCLES(TWR)
  ) dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .bus     (bus),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic noteEvent(input logic [10:0] ev);
    logic [10:0] e;
    if (exp_events.size() == 0) begin
      checkOutput("bus_event_unexpected", 32'(ev), 32'h7ff);
    end else begin
      e = exp_events.pop_front();
      checkOutput("bus_event", 32'(ev), 32'(e));
    end
  endtask

  // Bus decoder plus ACKing slave; SCL/SDA are sampled mid-cycle.
  always @(negedge clk) begin
    cur_scl = scl;
    cur_sda = sda;
    if (!mon_en) begin
      in_frame  = 1'b0;
      bit_idx   = 0;
      byte_idx  = 0;
      slave_low = 1'b0;
    end else if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
      checkOutput("start_on_idle_bus", 32'(in_frame), 32'd0);
      noteEvent(EV_START);
      in_frame = 1'b1;
      bit_idx  = 0;
      byte_idx = 0;
    end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
      checkOutput("stop_inside_frame", 32'(in_frame), 32'd1);
      noteEvent(EV_STOP);
      in_frame = 1'b0;
      bit_idx  = 0;
    end else if (!prev_scl && cur_scl && in_frame) begin
      if (bit_idx < 8) begin
        shreg   = {shreg[6:0], cur_sda};
        bit_idx = bit_idx + 1;
      end else begin
        noteEvent({2'b00, cur_sda, shreg});
        bit_idx  = 0;
        byte_idx = byte_idx + 1;
      end
    end else if (prev_scl && !cur_scl && in_frame) begin
      slave_low = (bit_idx == 8) && (byte_idx != nack_idx);
    end
    prev_scl = cur_scl;
    prev_sda = sda;
  end

  // DONE monitor: checks status in the DONE cycle and the length of the BUSY window.
  always @(negedge clk) begin
    done_t e;
    if (!mon_en) begin
      busy_cnt = 0;
    end else if (bus.DONE) begin
      done_seen++;
      if (exp_done.size() == 0) begin
        checkOutput("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_done.pop_front();
        checkOutput("done_ack_err", 32'(bus.ACK_ERR), 32'(e.ack_err));
        checkOutput("done_busy_low", 32'(bus.BUSY), 32'd0);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
      end
      busy_cnt = 0;
    end else if (bus.BUSY) begin
      busy_cnt++;
    end
  end

  task automatic expectTransaction(input vec_t v);
    logic [7:0] bytes[3];
    done_t d;
    bytes[0] = 8'hA0;
    bytes[1] = v.addr;
    bytes[2] = v.data;
    exp_events.push_back(EV_START);
    for (int i = 0; i < 3; i++) begin
      exp_events.push_back({2'b00, (i == v.nack_at), bytes[i]});
      if (i == v.nack_at) break;
    end
    exp_events.push_back(EV_STOP);
    d.ack_err = v.exp_ack_err;
    d.cycles  = v.exp_busy;
    exp_done.push_back(d);
    done_target++;
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.MEM_ADDR = addr;
    bus.WR_DATA  = data;
    bus.WRITE    = 1'b0;
    repeat (3) @(negedge clk);
    bus.WRITE = 1'b1;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done_seen < done_target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_reached", 32'(done_seen), 32'(done_target));
    repeat (30) @(negedge clk);
    checkOutput("events_drained", 32'(exp_events.size()), 32'd0);
    checkOutput("dones_drained", 32'(exp_done.size()), 32'd0);
    checkOutput("single_done", 32'(done_seen), 32'(done_target));
  endtask

  task automatic waitState(input logic [3:0] st);
    int n = 0;
    while (bus.STATE_OUT != st && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("state_reached", 32'(bus.STATE_OUT), 32'(st));
  endtask

  task automatic runVector(input vec_t v);
    nack_idx = v.nack_at;
    expectTransaction(v);
    applyStimulus(v.addr, v.data);
    waitDone();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vec_t v;
    int   n;
    vecs[0] = '{addr: 8'h3C, data: 8'hA5, nack_at: 3, exp_ack_err: 1'b0, exp_busy: 480};
    vecs[1] = '{addr: 8'h3C, data: 8'hA5, nack_at: 0, exp_ack_err: 1'b1, exp_busy: 176};
    vecs[2] = '{addr: 8'h3C, data: 8'hA5, nack_at: 2, exp_ack_err: 1'b1, exp_busy: 464};
    vecs[3] = '{addr: 8'h00, data: 8'hFF, nack_at: 3, exp_ack_err: 1'b0, exp_busy: 480};

    bus.WRITE    = 1'b1;
    bus.MEM_ADDR = 8'h00;
    bus.WR_DATA  = 8'h00;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_scl", 32'(scl), 32'd1);
    checkOutput("rst_sda", 32'(sda), 32'd1);
    checkOutput("rst_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("rst_done", 32'(bus.DONE), 32'd0);
    checkOutput("rst_ack_err", 32'(bus.ACK_ERR), 32'd0);
    checkOutput("rst_state", 32'(bus.STATE_OUT), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_state", 32'(bus.STATE_OUT), 32'd0);
    checkOutput("idle_scl", 32'(scl), 32'd1);
    mon_en = 1'b1;
    @(negedge clk);

    $display("[TB] success write 0x3C <= 0xA5");
    runVector(vecs[0]);
    $display("[TB] NACK on device address");
    runVector(vecs[1]);
    $display("[TB] NACK on data byte");
    runVector(vecs[2]);

    $display("[TB] next request clears ACK_ERR");
    checkOutput("ack_err_sticky", 32'(bus.ACK_ERR), 32'd1);
    v = vecs[3];
    nack_idx = v.nack_at;
    expectTransaction(v);
    applyStimulus(v.addr, v.data);
    n = 0;
    while (!bus.BUSY && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_after_accept", 32'(bus.BUSY), 32'd1);
    checkOutput("ack_err_cleared", 32'(bus.ACK_ERR), 32'd0);
    waitDone();

    $display("[TB] second request during WORD byte is ignored");
    v = '{addr: 8'hC3, data: 8'h5A, nack_at: 3, exp_ack_err: 1'b0, exp_busy: 480};
    nack_idx = v.nack_at;
    expectTransaction(v);
    applyStimulus(v.addr, v.data);
    waitState(4'd4);
    applyStimulus(8'hFF, 8'h11);
    waitDone();

    $display("[TB] reset during DATA bit 3");
    v = '{addr: 8'h7E, data: 8'h18, nack_at: 3, exp_ack_err: 1'b0, exp_busy: 480};
    nack_idx = v.nack_at;
    expectTransaction(v);
    done_target--;
    applyStimulus(v.addr, v.data);
    waitState(4'd6);
    repeat (3 * SLOT + 2 * CLK_DIV) @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("abort_scl", 32'(scl), 32'd1);
    checkOutput("abort_sda", 32'(sda), 32'd1);
    checkOutput("abort_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("abort_state", 32'(bus.STATE_OUT), 32'd0);
    exp_events.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    $display("[TB] write after reset");
    runVector('{addr: 8'h55, data: 8'h0F, nack_at: 3, exp_ack_err: 1'b0, exp_busy: 480});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
